// File: rtl/inv_key_gen.sv
// AES-128 inverse key schedule. Loads the last round key and walks the schedule
// backwards, handing out one round key per handshake down to round 0.
module inv_key_gen #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] keyIn,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] roundKey,
    output logic [3:0]   round,
    output logic         busy,
    output logic         done
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] START_ROUND = 4'(NUM_ROUNDS);

    // Forward S-box with entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // 255 - b == ~b, so the byte for entry b sits at 8*(~b).
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Round r key -> round r-1 key; byte 0 of each word is in its low bits.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] p3;
        p3 = k[127:96] ^ k[95:64];
        p2 = k[95:64] ^ k[63:32];
        p1 = k[63:32] ^ k[31:0];
        p0 = k[31:0] ^ sub_word({p3[7:0], p3[31:8]}) ^ {24'h000000, rcon(r)};
        return {p3, p2, p1, p0};
    endfunction

    state_t       state_r;
    state_t       state_nxt_s;
    logic [127:0] key_r;
    logic [127:0] key_nxt_s;
    logic [127:0] step_key_s;
    logic [3:0]   round_r;
    logic [3:0]   round_nxt_s;
    logic         done_r;
    logic         done_nxt_s;

    assign step_key_s = inv_step(key_r, round_r);

    // Next-state and datapath update for the load / emit handshake.
    always_comb begin
        state_nxt_s = state_r;
        key_nxt_s   = key_r;
        round_nxt_s = round_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = EMIT;
                    key_nxt_s   = keyIn;
                    round_nxt_s = START_ROUND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (round_r != 4'd0) begin
                        key_nxt_s   = step_key_s;
                        round_nxt_s = round_r - 4'd1;
                    end else begin
                        state_nxt_s = IDLE;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset beats start and any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            key_r   <= 128'h0;
            round_r <= 4'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            key_r   <= key_nxt_s;
            round_r <= round_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign key_valid = (state_r == EMIT);
    assign busy      = (state_r == EMIT);
    assign roundKey  = key_r;
    assign round     = round_r;
    assign done      = done_r;

endmodule

// File: tb/tb_inv_key_gen.sv
// Self-checking bench for inv_key_gen: scoreboard of expected (round, key)
// pairs pushed at start and popped on every accepted handshake.
`timescale 1ns/1ps
module tb_inv_key_gen;
    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, key_ready, key_valid, busy, done;
    logic [127:0] key_in, round_key;
    logic [3:0]   round;
    logic         start3, ready3, valid3, busy3, done3;
    logic [127:0] key_in3, round_key3;
    logic [3:0]   round3;

    inv_key_gen dut (
        .clk(clk), .rst(rst), .start(start), .keyIn(key_in), .key_ready(key_ready),
        .key_valid(key_valid), .roundKey(round_key), .round(round), .busy(busy), .done(done)
    );

    inv_key_gen #(.NUM_ROUNDS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .keyIn(key_in3), .key_ready(ready3),
        .key_valid(valid3), .roundKey(round_key3), .round(round3), .busy(busy3), .done(done3)
    );

    // FIPS-197 appendix A.1 round keys, written in AES byte order.
    localparam logic [127:0] FIPS [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // AES byte i goes to bits [8i+7:8i] of the packed key.
    function automatic logic [127:0] exp_key(input int r);
        logic [127:0] f;
        logic [127:0] k;
        f = FIPS[r];
        for (int i = 0; i < 16; i++) k[8*i +: 8] = f[127-8*i -: 8];
        return k;
    endfunction

    task automatic push_sweep(input int top);
        exp_t e;
        for (int r = top; r >= 0; r--) begin
            e.rnd = 4'(r);
            e.key = exp_key(r);
            sb_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = 128'h0;
        start3 = 1'b0; ready3 = 1'b0; key_in3 = 128'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        n_cmp++; if (round_key !== 128'h0) begin n_err++; $display("FAIL reset_key: got %h expected 0", round_key); end
        n_cmp++; if (round !== 4'd0) begin n_err++; $display("FAIL reset_round: got %0d expected 0", round); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (valid3 !== 1'b0) begin n_err++; $display("FAIL reset_valid3: got %b expected 0", valid3); end
        rst = 1'b0;
    endtask

    task automatic test_full_sweep();
        exp_t e;
        int   cycles;
        start = 1'b1; key_in = exp_key(10); key_ready = 1'b1;
        push_sweep(10);
        @(negedge clk);
        start = 1'b0; key_in = 128'h0;
        cycles = 0;
        while (sb_q.size() != 0 && cycles < 40) begin
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL sweep_done_early: got %b expected 0", done); end
            if (key_valid && key_ready) begin
                e = sb_q.pop_front();
                n_cmp++; if (round !== e.rnd) begin n_err++; $display("FAIL sweep_round: got %0d expected %0d", round, e.rnd); end
                n_cmp++; if (round_key !== e.key) begin n_err++; $display("FAIL sweep_key r%0d: got %h expected %h", e.rnd, round_key, e.key); end
            end
            cycles++;
            @(negedge clk);
        end
        n_cmp++; if (cycles != 11) begin n_err++; $display("FAIL sweep_cycles: got %0d expected 11", cycles); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sweep_done: got %b expected 1", done); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL sweep_valid_after: got %b expected 0", key_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_busy_after: got %b expected 0", busy); end
        n_cmp++; if (round_key !== exp_key(0)) begin n_err++; $display("FAIL sweep_hold_key: got %h expected %h", round_key, exp_key(0)); end
        n_cmp++; if (round !== 4'd0) begin n_err++; $display("FAIL sweep_hold_round: got %0d expected 0", round); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL sweep_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_backpressure();
        exp_t         e;
        int           cycles, stalls, low_cnt;
        bit           tog, held;
        logic [127:0] held_key;
        logic [3:0]   held_round;
        start = 1'b1; key_in = exp_key(10); key_ready = 1'b0;
        push_sweep(10);
        @(negedge clk);
        start = 1'b0;
        cycles = 0; stalls = 0; low_cnt = 0; tog = 1'b1; held = 1'b0;
        held_key = 128'h0; held_round = 4'd0;
        while (sb_q.size() != 0 && cycles < 80) begin
            if (held) begin
                n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold: got %b expected 1", key_valid); end
                n_cmp++; if (round_key !== held_key) begin n_err++; $display("FAIL bp_key_hold: got %h expected %h", round_key, held_key); end
                n_cmp++; if (round !== held_round) begin n_err++; $display("FAIL bp_round_hold: got %0d expected %0d", round, held_round); end
            end
            if (round == 4'd7 && low_cnt < 5) begin
                key_ready = 1'b0;
                low_cnt++;
            end else begin
                key_ready = tog;
                tog = ~tog;
            end
            if (key_valid && key_ready) begin
                e = sb_q.pop_front();
                held = 1'b0;
                n_cmp++; if (round !== e.rnd) begin n_err++; $display("FAIL bp_round: got %0d expected %0d", round, e.rnd); end
                n_cmp++; if (round_key !== e.key) begin n_err++; $display("FAIL bp_key r%0d: got %h expected %h", e.rnd, round_key, e.key); end
            end else begin
                held = 1'b1; held_key = round_key; held_round = round;
                stalls++;
            end
            cycles++;
            @(negedge clk);
        end
        n_cmp++; if (cycles != 11 + stalls) begin n_err++; $display("FAIL bp_cycles: got %0d expected %0d", cycles, 11 + stalls); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b expected 1", done); end
        key_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        int   cycles;
        start = 1'b1; key_in = exp_key(10); key_ready = 1'b1;
        push_sweep(10);
        @(negedge clk);
        cycles = 0;
        while (sb_q.size() != 0 && cycles < 40) begin
            start = 1'b0;
            if (key_valid && round == 4'd6) begin
                start = 1'b1; key_in = 128'h0;
            end
            if (key_valid && key_ready) begin
                e = sb_q.pop_front();
                n_cmp++; if (round !== e.rnd) begin n_err++; $display("FAIL busy_round: got %0d expected %0d", round, e.rnd); end
                n_cmp++; if (round_key !== e.key) begin n_err++; $display("FAIL busy_key r%0d: got %h expected %h", e.rnd, round_key, e.key); end
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_done: got %b expected 1", done); end
        @(negedge clk);
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL busy_no_restart: got %b expected 0", key_valid); end
    endtask

    task automatic test_reset_mid_sweep();
        int cycles;
        bit hit;
        start = 1'b1; key_in = exp_key(10); key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0; hit = 1'b0;
        while (!hit && cycles < 40) begin
            if (key_valid && round == 4'd4) begin
                rst = 1'b1; start = 1'b1; hit = 1'b1;
            end else begin
                cycles++;
                @(negedge clk);
            end
        end
        n_cmp++; if (!hit) begin n_err++; $display("FAIL rst_reach_r4: got timeout expected round 4"); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", key_valid); end
        n_cmp++; if (round !== 4'd0) begin n_err++; $display("FAIL rst_round: got %0d expected 0", round); end
        n_cmp++; if (round_key !== 128'h0) begin n_err++; $display("FAIL rst_key: got %h expected 0", round_key); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_no_done: got %b expected 0", done); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rst_stay_idle: got %b expected 0", key_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cycles;
        start = 1'b1; key_in = exp_key(10); key_ready = 1'b1;
        push_sweep(10);
        @(negedge clk);
        start = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            cycles = 0;
            while (sb_q.size() != 0 && cycles < 40) begin
                if (key_valid && key_ready) begin
                    e = sb_q.pop_front();
                    n_cmp++; if (round !== e.rnd) begin n_err++; $display("FAIL b2b_round p%0d: got %0d expected %0d", pass, round, e.rnd); end
                    n_cmp++; if (round_key !== e.key) begin n_err++; $display("FAIL b2b_key p%0d r%0d: got %h expected %h", pass, e.rnd, round_key, e.key); end
                end
                cycles++;
                @(negedge clk);
            end
            n_cmp++; if (cycles != 11) begin n_err++; $display("FAIL b2b_cycles p%0d: got %0d expected 11", pass, cycles); end
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done p%0d: got %b expected 1", pass, done); end
            if (pass == 0) begin
                start = 1'b1; key_in = exp_key(10);
                push_sweep(10);
                @(negedge clk);
                start = 1'b0;
                n_cmp++; if (key_valid !== 1'b1 || round !== 4'd10) begin
                    n_err++; $display("FAIL b2b_restart: got valid=%b round=%0d expected valid=1 round=10", key_valid, round);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_param();
        exp_t e;
        int   cycles;
        start3 = 1'b1; key_in3 = exp_key(3); ready3 = 1'b1;
        push_sweep(3);
        @(negedge clk);
        start3 = 1'b0;
        cycles = 0;
        while (sb_q.size() != 0 && cycles < 20) begin
            if (valid3 && ready3) begin
                e = sb_q.pop_front();
                n_cmp++; if (round3 !== e.rnd) begin n_err++; $display("FAIL param_round: got %0d expected %0d", round3, e.rnd); end
                n_cmp++; if (round_key3 !== e.key) begin n_err++; $display("FAIL param_key r%0d: got %h expected %h", e.rnd, round_key3, e.key); end
            end
            cycles++;
            @(negedge clk);
        end
        n_cmp++; if (cycles != 4) begin n_err++; $display("FAIL param_cycles: got %0d expected 4", cycles); end
        n_cmp++; if (done3 !== 1'b1 || valid3 !== 1'b0) begin
            n_err++; $display("FAIL param_done: got done=%b valid=%b expected done=1 valid=0", done3, valid3);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_back_to_back();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
